// File: rtl/idex_skid_reg.sv
// idex_skid_reg: elastic ID/EX pipeline register built as a 2-entry skid buffer.
//
// Ports:
//   CLK, RST_N        clock (rising edge) and asynchronous active-low reset
//   flush             synchronous squash of every held entry
//   in_valid/in_ready decode-side handshake; in_ready comes from a register only
//   in_*              decoded instruction payload (ctrl, r1, r2, sext, rd, func3, func7)
//   out_valid/out_ready EX-side handshake
//   out_*             head-entry payload; out_ctrl is forced to 0 on a bubble
//   stall_cnt         saturating count of cycles with out_valid=1 and out_ready=0
//
// Entry M drives the outputs; entry S catches the one instruction accepted while M is
// blocked, so in_ready never depends combinationally on out_ready.
module idex_skid_reg #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned RADDR_W = 5,
   parameter int unsigned CTRL_W  = 7,
   parameter int unsigned CNT_W   = 16
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               flush,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [CTRL_W-1:0]  in_ctrl,
   input  logic [XLEN-1:0]    in_r1,
   input  logic [XLEN-1:0]    in_r2,
   input  logic [XLEN-1:0]    in_sext,
   input  logic [RADDR_W-1:0] in_rd,
   input  logic [2:0]         in_func3,
   input  logic [6:0]         in_func7,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CTRL_W-1:0]  out_ctrl,
   output logic [XLEN-1:0]    out_r1,
   output logic [XLEN-1:0]    out_r2,
   output logic [XLEN-1:0]    out_sext,
   output logic [RADDR_W-1:0] out_rd,
   output logic [2:0]         out_func3,
   output logic [6:0]         out_func7,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam int unsigned PW = CTRL_W + 3 * XLEN + RADDR_W + 3 + 7;
   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = {{(CNT_W - 1){1'b0}}, 1'b1};

   logic          m_valid_q, m_valid_d;
   logic          s_valid_q, s_valid_d;
   logic [PW-1:0] m_data_q, m_data_d;
   logic [PW-1:0] s_data_q, s_data_d;
   logic [PW-1:0] in_data;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CTRL_W-1:0] m_ctrl;
   logic          accept, issue;

   assign in_data = {in_ctrl, in_r1, in_r2, in_sext, in_rd, in_func3, in_func7};

   assign in_ready  = ~s_valid_q;
   assign accept    = in_valid & in_ready;
   assign out_valid = m_valid_q;
   assign issue     = m_valid_q & out_ready;

   assign {m_ctrl, out_r1, out_r2, out_sext, out_rd, out_func3, out_func7} = m_data_q;
   // A bubble must never assert register or memory writes downstream.
   assign out_ctrl  = m_ctrl & {CTRL_W{m_valid_q}};
   assign stall_cnt = stall_q;

   always_comb begin
      m_valid_d = m_valid_q;
      s_valid_d = s_valid_q;
      m_data_d  = m_data_q;
      s_data_d  = s_data_q;
      if (flush) begin
         // An issue this cycle has already been seen by EX; everything held is dropped.
         m_valid_d = 1'b0;
         s_valid_d = 1'b0;
      end else if (issue && s_valid_q) begin
         // in_ready is low whenever S is full, so no accept can coincide here.
         m_data_d  = s_data_q;
         s_valid_d = 1'b0;
      end else if (issue || !m_valid_q) begin
         m_valid_d = accept;
         // Payload only loads on accept so data outputs hold through bubbles.
         if (accept) begin
            m_data_d = in_data;
         end
      end else if (accept) begin
         s_data_d  = in_data;
         s_valid_d = 1'b1;
      end
   end

   always_comb begin
      stall_d = stall_q;
      if (m_valid_q && !out_ready && (stall_q != CntMax)) begin
         stall_d = stall_q + CntOne;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         m_valid_q <= 1'b0;
         s_valid_q <= 1'b0;
         m_data_q  <= '0;
         s_data_q  <= '0;
         stall_q   <= '0;
      end else begin
         m_valid_q <= m_valid_d;
         s_valid_q <= s_valid_d;
         m_data_q  <= m_data_d;
         s_data_q  <= s_data_d;
         stall_q   <= stall_d;
      end
   end

endmodule
